// File: rtl/conv1_tap_mult.sv
// conv1_tap_mult
// Input-side datapath slice of a conv-layer-1 processing element.
// A 3-tap shift line of unsigned 8-bit pixels feeds three 8x8 multipliers,
// one per kernel column. Products are 20-bit signed (sign-extended 17-bit).
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset, clears taps (and product regs)
//   en        in   1   shift/compute enable
//   ifmap_in  in   8   unsigned pixel entering tap 0
//   filtr_in  in  24   signed weights: [7:0] tap0, [15:8] tap1, [23:16] tap2
//   tap0..2   out  8   shift-line taps (tap0 newest, forwarded to next PE)
//   prod0..2  out 20   signed tapN * weightN
//
// Build option:
//   CONV1_MULT_PIPE_EN  defined   -> each product is registered (loaded when en=1),
//                                    adding one enabled cycle of latency.
//                       undefined -> products are combinational from taps and weights.
module conv1_tap_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  ifmap_in,
  input  logic [23:0] filtr_in,
  output logic [7:0]  tap0,
  output logic [7:0]  tap1,
  output logic [7:0]  tap2,
  output logic [19:0] prod0,
  output logic [19:0] prod1,
  output logic [19:0] prod2
);

  logic [7:0]  tap0_q, tap1_q, tap2_q;
  logic [19:0] mult0_d, mult1_d, mult2_d;

  // Pixel is zero-extended to 9 bits so it stays non-negative in the signed
  // multiply; 9x8 signed fits in 17 bits, then sign-extended to 20.
  function automatic logic [19:0] tap_mult(input logic [7:0] px, input logic [7:0] w);
    logic signed [16:0] p;
    p = $signed({1'b0, px}) * $signed(w);
    return {{3{p[16]}}, p};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap0_q <= 8'd0;
      tap1_q <= 8'd0;
      tap2_q <= 8'd0;
    end else if (en) begin
      tap2_q <= tap1_q;
      tap1_q <= tap0_q;
      tap0_q <= ifmap_in;
    end
  end

  always_comb begin
    mult0_d = tap_mult(tap0_q, filtr_in[7:0]);
    mult1_d = tap_mult(tap1_q, filtr_in[15:8]);
    mult2_d = tap_mult(tap2_q, filtr_in[23:16]);
  end

`ifdef CONV1_MULT_PIPE_EN
  logic [19:0] prod0_q, prod1_q, prod2_q;

  // Captures the product of the taps and weights present at the enabled edge,
  // i.e. before the shift line moves on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod0_q <= 20'd0;
      prod1_q <= 20'd0;
      prod2_q <= 20'd0;
    end else if (en) begin
      prod0_q <= mult0_d;
      prod1_q <= mult1_d;
      prod2_q <= mult2_d;
    end
  end

  assign prod0 = prod0_q;
  assign prod1 = prod1_q;
  assign prod2 = prod2_q;
`else
  assign prod0 = mult0_d;
  assign prod1 = mult1_d;
  assign prod2 = mult2_d;
`endif

  assign tap0 = tap0_q;
  assign tap1 = tap1_q;
  assign tap2 = tap2_q;

endmodule

// File: tb/tb_conv1_tap_mult.sv
module tb_conv1_tap_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  ifmap_in = 8'd0;
  logic [23:0] filtr_in = 24'd0;
  logic [7:0]  tap0, tap1, tap2;
  logic [19:0] prod0, prod1, prod2;

  conv1_tap_mult dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ifmap_in(ifmap_in), .filtr_in(filtr_in),
    .tap0(tap0), .tap1(tap1), .tap2(tap2),
    .prod0(prod0), .prod1(prod1), .prod2(prod2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t0, t1, t2;
    logic [19:0] p0, p1, p2;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Reference: pixel history, newest first, plus registered products for the pipelined build.
  int hist[3] = '{0, 0, 0};
  logic [19:0] pipe_p[3] = '{20'd0, 20'd0, 20'd0};

  function automatic logic [19:0] ref_prod(input int px, input logic [7:0] w);
    int r;
    r = px * int'($signed(w));
    return r[19:0];
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%05h required=0x%05h at %0t", name, act, req, $time);
    end
  endtask

  // Applies one cycle of stimulus at the falling edge and pushes the state
  // expected after the following rising edge.
  task automatic drive(input logic e, input logic [7:0] px, input logic [23:0] f, input logic rel);
    exp_t x;
    logic [7:0] w[3];
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    en = e;
    ifmap_in = px;
    filtr_in = f;
    w[0] = f[7:0];
    w[1] = f[15:8];
    w[2] = f[23:16];
    if (e && rst_n) begin
      for (int k = 0; k < 3; k++) pipe_p[k] = ref_prod(hist[k], w[k]);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(px);
    end
    x.t0 = hist[0][7:0];
    x.t1 = hist[1][7:0];
    x.t2 = hist[2][7:0];
`ifdef CONV1_MULT_PIPE_EN
    x.p0 = pipe_p[0];
    x.p1 = pipe_p[1];
    x.p2 = pipe_p[2];
`else
    x.p0 = ref_prod(hist[0], w[0]);
    x.p1 = ref_prod(hist[1], w[1]);
    x.p2 = ref_prod(hist[2], w[2]);
`endif
    sb_q.push_back(x);
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tap0", {12'd0, tap0}, 20'd0);
    check("async_rst_tap1", {12'd0, tap1}, 20'd0);
    check("async_rst_tap2", {12'd0, tap2}, 20'd0);
    check("async_rst_prod0", prod0, 20'd0);
    check("async_rst_prod1", prod1, 20'd0);
    check("async_rst_prod2", prod2, 20'd0);
    for (int k = 0; k < 3; k++) begin
      hist[k] = 0;
      pipe_p[k] = 20'd0;
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("tap0", {12'd0, tap0}, {12'd0, x.t0});
        check("tap1", {12'd0, tap1}, {12'd0, x.t1});
        check("tap2", {12'd0, tap2}, {12'd0, x.t2});
        check("prod0", prod0, x.p0);
        check("prod1", prod1, x.p1);
        check("prod2", prod2, x.p2);
      end
    end
  end

  initial begin
    // Release reset with en low: zeros must hold across edges.
    drive(1'b0, 8'd55, 24'h02FF01, 1'b1);
    drive(1'b0, 8'd56, 24'h02FF01, 1'b0);
    // Shift order and signed products.
    drive(1'b1, 8'd10, 24'h02FF01, 1'b0);
    drive(1'b1, 8'd20, 24'h02FF01, 1'b0);
    drive(1'b1, 8'd30, 24'h02FF01, 1'b0);
    drive(1'b1, 8'd40, 24'h02FF01, 1'b0);
    // Stall with changing input.
    drive(1'b0, 8'd99, 24'h02FF01, 1'b0);
    drive(1'b0, 8'd99, 24'h02FF01, 1'b0);
    drive(1'b0, 8'd99, 24'h02FF01, 1'b0);
    drive(1'b1, 8'd99, 24'h02FF01, 1'b0);
    // Extremes.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd255, 24'h807F80, 1'b0);
    drive(1'b0, 8'd0, 24'h807F80, 1'b0);
    // Mid-stream reset with nonzero taps, then release with en low.
    mid_reset();
    drive(1'b1, 8'd77, 24'h807F80, 1'b0);
    drive(1'b0, 8'd78, 24'h807F80, 1'b1);
    drive(1'b0, 8'd79, 24'h807F80, 1'b0);
    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) begin
        mid_reset();
        drive(1'b0, 8'($urandom), 24'($urandom), 1'b1);
      end else begin
        drive(($urandom_range(3) != 0), 8'($urandom), 24'($urandom), 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
